// File: rtl/sumador_pc.sv
// sumador_pc: PC incrementer, ripple-carry a_i + INC with registered copy.
// Define SUMADORPC_CARRY_EN to expose the combinational carry_o port.
module sumador_pc #(
  parameter int N = 32,
  parameter logic [N-1:0] INC = N'(4),
  parameter logic [N-1:0] RESET_VAL = '0
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         en_i,
  input  logic [N-1:0] a_i,
  output logic [N-1:0] sum_o,
  output logic [N-1:0] sum_q_o
`ifdef SUMADORPC_CARRY_EN
  ,
  output logic         carry_o
`endif
);
  logic [N-1:0] c;
  logic [N-1:0] sum_q_d, sum_q_q;
  assign c[0] = 1'b0;
  for (genvar i = 0; i < N; i++) begin : g_fa
    assign sum_o[i] = a_i[i] ^ INC[i] ^ c[i];
    if (i < N - 1) begin : g_c
      assign c[i+1] = (a_i[i] & INC[i]) | (c[i] & (a_i[i] ^ INC[i]));
    end
  end
`ifdef SUMADORPC_CARRY_EN
  assign carry_o = (a_i[N-1] & INC[N-1]) | (c[N-1] & (a_i[N-1] ^ INC[N-1]));
`endif
  always_comb sum_q_d = en_i ? sum_o : sum_q_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) sum_q_q <= RESET_VAL;
    else sum_q_q <= sum_q_d;
  end
  assign sum_q_o = sum_q_q;
endmodule

// File: tb/tb_sumador_pc.sv
// tb_sumador_pc: directed checks of sumador_pc with N=4, INC=4, RESET_VAL=0.
module tb_sumador_pc;
  logic clk = 1'b0, clk_on = 1'b0;
  logic rst_n, en;
  logic [3:0] a, sum, sum_q;
  int n_chk = 0, n_ok = 0;
`ifdef SUMADORPC_CARRY_EN
  logic carry;
`endif

  sumador_pc #(.N(4), .INC(4'd4), .RESET_VAL(4'd0)) dut (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .a_i(a),
    .sum_o(sum), .sum_q_o(sum_q)
`ifdef SUMADORPC_CARRY_EN
    , .carry_o(carry)
`endif
  );

  always begin
    #5;
    if (clk_on) clk = ~clk;
  end

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_chk++;
    if (got === exp) n_ok++;
    else $display("FAIL %s: got %b expected %b", tag, got, exp);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; a = 4'b0000;
    #10;
    chk("idle_sum", sum, 4'b0100);
    chk("reset_q", sum_q, 4'b0000);
    a = 4'b0101; #1;
    chk("sum_5", sum, 4'b1001);
`ifdef SUMADORPC_CARRY_EN
    chk("carry_5", {3'b0, carry}, 4'd0);
`endif
    a = 4'b1111; #1;
    chk("sum_wrap", sum, 4'b0011);
`ifdef SUMADORPC_CARRY_EN
    chk("carry_wrap", {3'b0, carry}, 4'd1);
`endif
    clk_on = 1'b1;
    @(negedge clk); rst_n = 1'b1; en = 1'b1;
    @(posedge clk); #1;
    chk("load_wrap", sum_q, 4'b0011);
    a = 4'b0101; rst_n = 1'b0; #1;
    chk("async_rst_q", sum_q, 4'b0000);
    chk("rst_sum", sum, 4'b1001);
    @(posedge clk); #1;
    chk("rst_over_en", sum_q, 4'b0000);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("first_load", sum_q, 4'b1001);
    @(negedge clk); en = 1'b0; a = 4'b1100;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("hold_q", sum_q, 4'b1001);
      chk("hold_sum", sum, 4'b0000);
    end
    @(negedge clk); en = 1'b1;
    for (int v = 0; v < 16; v++) begin
      @(negedge clk); a = 4'(v); #1;
      chk("sweep_sum", sum, 4'(v + 4));
      @(posedge clk); #1;
      chk("sweep_q", sum_q, 4'(v + 4));
    end
    $display("%0d/%0d checks passed", n_ok, n_chk);
    $finish;
  end
endmodule
